// File: rtl/freq_gen_if.sv
// Control and status bundle for freq_gen: frequency request handshake plus generated-clock status.
// Handshake: a request is taken on a rising clk_stand edge where load and ready are both high; load while ready is low is dropped.
interface freq_gen_if #(
  parameter int FW = 24,
  parameter int DW = 32
);
  logic [FW-1:0] freq_hz;
  logic          load;
  logic          ready;
  logic          clk_out;
  logic          running;
  logic          err;
  logic [DW-1:0] cur_half;
  logic [DW-1:0] edge_cnt;
  logic [1:0]    dbg_state;

  modport master (
    output freq_hz, load,
    input  ready, clk_out, running, err, cur_half, edge_cnt, dbg_state
  );

  modport slave (
    input  freq_hz, load,
    output ready, clk_out, running, err, cur_half, edge_cnt, dbg_state
  );
endinterface

// File: rtl/freq_gen.sv
// Programmable square-wave generator: Hz request -> half-period via restoring division,
// new half-periods installed only at phase boundaries so clk_out never glitches.
module freq_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int FW     = 24,
  parameter int DW     = 32
) (
  input  logic        clk_stand,
  input  logic        rst,
  freq_gen_if.slave   bus
);
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] CLK_DVD = DW'(CLK_HZ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    APPLY = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t        state;
  logic [FW-1:0] freq_q;
  logic          stop_q;
  logic [DW-1:0] dvd;
  logic [DW-1:0] quo;
  logic [FW:0]   rem;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] half_q;
  logic [DW-1:0] phase_cnt;
  logic          clk_out_q;
  logic          running_q;
  logic          err_q;
  logic [DW-1:0] cur_half_q;
  logic [DW-1:0] edge_cnt_q;

  logic [FW:0]   divisor;
  logic [FW+1:0] rem_sh;
  logic [FW+1:0] rem_sub;
  logic          sub_ok;
  logic [DW-1:0] quo_next;
  logic          phase_end;
  logic          stop_now;
  logic          load_ok;

  always_comb begin
    divisor   = {freq_q, 1'b0};
    rem_sh    = {rem, dvd[DW-1]};
    sub_ok    = (rem_sh >= {1'b0, divisor});
    rem_sub   = rem_sh - {1'b0, divisor};
    quo_next  = {quo[DW-2:0], sub_ok};
    phase_end = running_q && (phase_cnt == cur_half_q - DW'(1));
    // A stop never cuts a high phase short; a low clk_out may stop at once.
    stop_now  = (state == APPLY) && stop_q && (!running_q || !clk_out_q || phase_end);
    load_ok   = bus.load && bus.ready;
  end

  assign bus.ready     = (state == IDLE) || (state == RUN);
  assign bus.clk_out   = clk_out_q;
  assign bus.running   = running_q;
  assign bus.err       = err_q;
  assign bus.cur_half  = cur_half_q;
  assign bus.edge_cnt  = edge_cnt_q;
  assign bus.dbg_state = state;

  always_ff @(posedge clk_stand) begin
    if (rst) begin
      state      <= IDLE;
      freq_q     <= '0;
      stop_q     <= 1'b0;
      dvd        <= '0;
      quo        <= '0;
      rem        <= '0;
      bit_cnt    <= '0;
      half_q     <= '0;
      phase_cnt  <= '0;
      clk_out_q  <= 1'b0;
      running_q  <= 1'b0;
      err_q      <= 1'b0;
      cur_half_q <= '0;
      edge_cnt_q <= '0;
    end else begin
      // The toggler keeps the old half-period alive through DIV and APPLY.
      if (running_q && !stop_now) begin
        if (phase_end) begin
          phase_cnt <= '0;
          clk_out_q <= ~clk_out_q;
          if (!clk_out_q && (edge_cnt_q != '1))
            edge_cnt_q <= edge_cnt_q + DW'(1);
        end else begin
          phase_cnt <= phase_cnt + DW'(1);
        end
      end

      case (state)
        IDLE, RUN: begin
          if (load_ok) begin
            freq_q     <= bus.freq_hz;
            err_q      <= 1'b0;
            edge_cnt_q <= '0;
            if (bus.freq_hz == '0) begin
              stop_q <= 1'b1;
              state  <= APPLY;
            end else begin
              stop_q  <= 1'b0;
              dvd     <= CLK_DVD;
              quo     <= '0;
              rem     <= '0;
              bit_cnt <= '0;
              state   <= DIV;
            end
          end
        end

        DIV: begin
          rem <= sub_ok ? rem_sub[FW:0] : rem_sh[FW:0];
          dvd <= {dvd[DW-2:0], 1'b0};
          quo <= quo_next;
          if (bit_cnt == CW'(DW - 1)) begin
            // Quotient 0 means the request is above CLK_HZ/2: clamp to the fastest toggle.
            if (quo_next == '0) begin
              half_q <= DW'(1);
              err_q  <= 1'b1;
            end else begin
              half_q <= quo_next;
            end
            state <= APPLY;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end

        APPLY: begin
          if (stop_q) begin
            if (stop_now) begin
              clk_out_q  <= 1'b0;
              running_q  <= 1'b0;
              cur_half_q <= '0;
              phase_cnt  <= '0;
              state      <= IDLE;
            end
          end else if (!running_q) begin
            cur_half_q <= half_q;
            phase_cnt  <= '0;
            clk_out_q  <= 1'b1;
            running_q  <= 1'b1;
            if (edge_cnt_q != '1)
              edge_cnt_q <= edge_cnt_q + DW'(1);
            state <= RUN;
          end else if (phase_end) begin
            cur_half_q <= half_q;
            state      <= RUN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_freq_gen.sv
// Directed bench for freq_gen: a monitor pops expected phase lengths from a scoreboard queue
// whenever clk_out changes level; stimulus also checks status outputs at hand-computed points.
module tb_freq_gen;
  localparam int CLK_HZ = 100_000_000;
  localparam int FW     = 26;
  localparam int DW     = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  freq_gen_if #(.FW(FW), .DW(DW)) bus ();

  freq_gen #(.CLK_HZ(CLK_HZ), .FW(FW), .DW(DW)) dut (
    .clk_stand (clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: measures each completed clk_out phase (in clk cycles) and compares against the queue.
  initial begin
    logic prev;
    logic started;
    int   cnt;
    prev = 1'b0;
    started = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        started = 1'b0;
        prev = bus.clk_out;
        cnt = 0;
      end else if (bus.clk_out !== prev) begin
        if (started && exp_q.size() > 0)
          check("phase_len", 32'(cnt), exp_q.pop_front());
        started = 1'b1;
        cnt = 1;
        prev = bus.clk_out;
      end else begin
        cnt++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [FW-1:0] f);
    @(negedge clk);
    bus.freq_hz = f;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_clk(input logic v, input int bound, input string name);
    int i;
    for (i = 0; i < bound; i++) begin
      if (bus.clk_out === v) break;
      @(negedge clk);
    end
    check(name, 32'(bus.clk_out === v), 32'd1);
  endtask

  task automatic wait_ready(input int bound, input string name);
    int i;
    for (i = 0; i < bound; i++) begin
      if (bus.ready === 1'b1) break;
      @(negedge clk);
    end
    check(name, 32'(bus.ready), 32'd1);
  endtask

  task automatic wait_drain(input int bound, input string name);
    int i;
    for (i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int k;
    int low_cnt;
    int rise_at;
    int rises;
    int high_seen;
    logic prev;

    bus.freq_hz = '0;
    bus.load = 1'b0;
    do_reset();

    // Reset state
    check("rst_clk_out", 32'(bus.clk_out), 32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_cur_half", bus.cur_half, 32'd0);
    check("rst_edge_cnt", bus.edge_cnt, 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);

    // 1 MHz from IDLE: 33 busy cycles, first rise DW+2 cycles after the load cycle, 50/50 phases
    mon_en = 1'b1;
    exp_q.push_back(32'd50); exp_q.push_back(32'd50);
    exp_q.push_back(32'd50); exp_q.push_back(32'd50);
    do_load(FW'(1_000_000));
    low_cnt = 0;
    rise_at = 0;
    for (k = 1; k <= 100; k++) begin
      if (bus.clk_out === 1'b1) begin
        rise_at = k;
        break;
      end
      if (bus.ready === 1'b0) low_cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(low_cnt), 32'd33);
    check("first_rise", 32'(rise_at), 32'(DW + 2));
    check("edge_after_first", bus.edge_cnt, 32'd1);
    wait_drain(400, "drain_1m");
    mon_en = 1'b0;
    check("cur_half_1m", bus.cur_half, 32'd50);
    check("running_1m", 32'(bus.running), 32'd1);
    check("err_1m", 32'(bus.err), 32'd0);

    // 300 kHz from IDLE: half 166, ten rising edges counted
    do_reset();
    mon_en = 1'b1;
    for (k = 0; k < 18; k++) exp_q.push_back(32'd166);
    do_load(FW'(300_000));
    rises = 0;
    prev = bus.clk_out;
    for (k = 0; k < 5000 && rises < 10; k++) begin
      @(negedge clk);
      if (!prev && bus.clk_out) rises++;
      prev = bus.clk_out;
    end
    check("rises_300k", 32'(rises), 32'd10);
    check("edge_cnt_10", bus.edge_cnt, 32'd10);
    wait_drain(400, "drain_300k");
    mon_en = 1'b0;
    check("cur_half_300k", bus.cur_half, 32'd166);

    // Retune 1 MHz -> 250 kHz early in a high phase: that phase stays 50, later ones 200
    do_reset();
    mon_en = 1'b1;
    exp_q.push_back(32'd50); exp_q.push_back(32'd50); exp_q.push_back(32'd50);
    exp_q.push_back(32'd200); exp_q.push_back(32'd200); exp_q.push_back(32'd200);
    do_load(FW'(1_000_000));
    wait_clk(1'b1, 100, "rise1_timeout");
    wait_clk(1'b0, 100, "fall1_timeout");
    wait_clk(1'b1, 100, "rise2_timeout");
    repeat (4) @(negedge clk);
    do_load(FW'(250_000));
    check("edge_cleared", bus.edge_cnt, 32'd0);
    check("ready_low_retune", 32'(bus.ready), 32'd0);
    wait_drain(2000, "drain_retune");
    mon_en = 1'b0;
    check("cur_half_250k", bus.cur_half, 32'd200);

    // Over-range request clamps to 1 and flags err; next load clears it
    do_reset();
    mon_en = 1'b1;
    for (k = 0; k < 6; k++) exp_q.push_back(32'd1);
    do_load(FW'(60_000_000));
    wait_drain(200, "drain_60m");
    mon_en = 1'b0;
    check("err_60m", 32'(bus.err), 32'd1);
    check("cur_half_60m", bus.cur_half, 32'd1);
    do_load(FW'(1_000_000));
    check("err_cleared", 32'(bus.err), 32'd0);
    wait_ready(100, "ready_after_60m");
    check("cur_half_back", bus.cur_half, 32'd50);

    // Stop request mid high phase: phase completes, then clk_out stays low
    do_reset();
    mon_en = 1'b1;
    exp_q.push_back(32'd50);
    do_load(FW'(1_000_000));
    wait_clk(1'b1, 100, "rise_stop_timeout");
    repeat (10) @(negedge clk);
    do_load('0);
    wait_drain(200, "drain_stop");
    mon_en = 1'b0;
    wait_ready(200, "ready_after_stop");
    check("stop_clk_out", 32'(bus.clk_out), 32'd0);
    check("stop_running", 32'(bus.running), 32'd0);
    check("stop_cur_half", bus.cur_half, 32'd0);
    high_seen = 0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.clk_out !== 1'b0) high_seen++;
    end
    check("stays_low", 32'(high_seen), 32'd0);

    // Load during DIV is ignored; then reset mid-run
    do_reset();
    do_load(FW'(1_000_000));
    repeat (5) @(negedge clk);
    bus.freq_hz = FW'(250_000);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    wait_ready(100, "ready_after_ignored");
    check("cur_half_ignored", bus.cur_half, 32'd50);
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_clk_out", 32'(bus.clk_out), 32'd0);
    check("midrst_running", 32'(bus.running), 32'd0);
    check("midrst_edge_cnt", bus.edge_cnt, 32'd0);
    check("midrst_state", 32'(bus.dbg_state), 32'd0);
    check("midrst_ready", 32'(bus.ready), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
Programmable square-wave generator running on the standard clock. It produces the test clock that frequency_calculate measures. The target frequency is given in Hz and converted internally to a half-period count by a sequential divider. Frequency changes are applied only at phase boundaries, so clk_out never carries a runt pulse. Used as the stimulus source on the board and in benches for the frequency meter.

Parameters:
CLK_HZ  100_000_000  frequency of clk_stand in Hz
FW  24  width of freq_hz
DW  32  width of divider quotient, half-period counter and edge counter

Ports:
clk_stand  in  1  standard clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
freq_hz  in  FW  requested output frequency, Hz; sampled on accepted load
load  in  1  one-cycle request; accepted only when ready=1
ready  out  1  high in IDLE and RUN; low in DIV and APPLY
clk_out  out  1  generated square wave
running  out  1  high while clk_out is toggling
err  out  1  sticky: requested frequency above CLK_HZ/2; cleared by next accepted load
cur_half  out  DW  half-period count currently in effect, in clk_stand cycles
edge_cnt  out  DW  rising edges of clk_out since last accepted load; saturates at all-ones

Behaviour:
- Reset, synchronous: state=IDLE, clk_out=0, running=0, err=0, cur_half=0, edge_cnt=0, ready=1, internal counters=0. Reset mid-division or mid-run aborts immediately.
- States: IDLE, DIV, APPLY, RUN.
- IDLE -> DIV on load&ready. RUN -> DIV on load&ready; clk_out keeps toggling with the old cur_half during DIV and APPLY.
- Load while ready=0 is ignored entirely.
- Accepted load: latch freq_hz, clear err, clear edge_cnt.
- DIV: restoring division CLK_HZ / (2*freq_hz), one quotient bit per cycle, exactly DW cycles. The divisor is FW+1 bits. Result is truncated: half = floor(CLK_HZ/(2*freq_hz)).
- DIV -> APPLY after the last quotient bit.
- Freq_hz=0 skips the division. It goes straight to APPLY with half marked "stop".
- Half==0 from a nonzero freq: half=1, err=1.
- APPLY, coming from IDLE: load cur_half=half, set phase count=0, clk_out=1 in the same cycle, running=1, then go to RUN. The first rising edge of clk_out is DW+2 cycles after the load cycle.
- APPLY, coming from RUN: wait until the current phase ends, i.e. the cycle where clk_out toggles. Then install the new half; the next phase uses it. The toggle itself still occurs.
- APPLY with "stop": at the next phase end where clk_out would fall (or immediately if clk_out=0), clk_out=0, running=0, cur_half=0, go to IDLE. clk_out never stops high.
- RUN: the phase counter counts 0..cur_half-1. At cur_half-1, clk_out toggles and the counter returns to 0. High and low phases are each cur_half cycles, so the period is 2*cur_half.
- edge_cnt increments on each 0->1 of clk_out, including the first edge from APPLY. It holds at 2^DW-1.
- A load accepted in the same cycle that a phase ends: the toggle happens, and the old half stays in effect until APPLY finds the next boundary.
- ready is combinational from state. All other outputs are registered.

Test Plan:
- Reset, then load freq_hz=1_000_000 -> ready low 33 cycles. clk_out rises DW+2 cycles after load. cur_half=50, 50 cycles high, 50 cycles low, running=1, err=0.
- Load 300_000 from IDLE -> cur_half=166, period 332 cycles. edge_cnt=10 after 10 rising edges.
- While running at 1_000_000, load 250_000 mid high-phase -> the current phase completes at 50 cycles and the next phases are 200 cycles. No pulse shorter than 50 cycles appears. edge_cnt resets to 0 at load.
- Load 60_000_000 -> cur_half=1, clk_out toggles every cycle, err=1. A following load of 1_000_000 clears err.
- Load 0 while running at 1_000_000 -> clk_out completes its high phase, falls, and stays 0. running=0, cur_half=0, ready=1.
- Pulse load during DIV -> ignored; result matches the first request. Assert rst mid-RUN -> next cycle clk_out=0, running=0, edge_cnt=0, state IDLE.
